proc_clk_ctrl: RTL and testbench

Consumes the slow debug clock `divclock` from the clock-divider stage and turns it into a processor clock enable, `cpu_en`. `cpu_en` is one CLOCK_50-wide pulse per processor tick. The processor core uses it as its single-cycle advance strobe.
The block adds board-level run/halt/single-step control from two pushbuttons and honours a halt request from the core. It sits between the divider and the processor core.

---
 rtl/proc_clk_ctrl_pkg.sv | 9 +
 rtl/proc_clk_ctrl_if.sv | 12 +
 rtl/proc_clk_ctrl_key_debounce.sv | 33 +++
 rtl/proc_clk_ctrl.sv | 67 ++++++
 tb/tb_proc_clk_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/proc_clk_ctrl_pkg.sv
// proc_ctrl_pkg: shared state encodings and defaults for the processor clock controller
package proc_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_e;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
endpackage

// File: rtl/proc_clk_ctrl_if.sv
// proc_clk_ctrl_if: divider tick, pushbuttons, halt request and processor strobe bundle
interface proc_clk_ctrl_if #(parameter int CNT_W = 16);
   logic             divclock;
   logic             key_mode;
   logic             key_step;
   logic             halt_req;
   logic             cpu_en;
   logic [1:0]       mode;
   logic [CNT_W-1:0] tick_count;
   modport master (output divclock, key_mode, key_step, halt_req, input cpu_en, mode, tick_count);
   modport slave  (input divclock, key_mode, key_step, halt_req, output cpu_en, mode, tick_count);
endinterface

// File: rtl/proc_clk_ctrl_key_debounce.sv
// key_debounce: synchronise an active-low pushbutton and emit one pulse per stable press
module key_debounce
   import proc_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic CLOCK_50,
   input  logic reset_n,
   input  logic key_n,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCE_CYCLES - 1);
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   // count stable low samples, saturate so a held key pulses only once
   always_comb begin
      sync_d = {sync_q[0], key_n};
      cnt_d  = sync_q[1] ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      press  = ~sync_q[1] & (cnt_q == CNT_ARM);
   end
   // synchroniser idles released (high), counter idles at zero
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/proc_clk_ctrl.sv
// proc_clk_ctrl: turns the divider tick into a gated processor strobe with run/halt/step control
module proc_clk_ctrl
   import proc_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = 16
) (
   input logic            CLOCK_50,
   input logic            reset_n,
   proc_clk_ctrl_if.slave bus
);
   logic [2:0]       div_q, div_d;
   logic             tick, gate, mode_press, step_press;
   state_e           state_q, state_d;
   logic             cpu_en_q, cpu_en_d;
   logic [CNT_W-1:0] tick_count_q, tick_count_d;
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .key_n    (bus.key_mode),
      .press    (mode_press)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .key_n    (bus.key_step),
      .press    (step_press)
   );
   // rising-edge detect on the synchronised divider clock, gate by the current state
   always_comb begin
      div_d   = {div_q[1:0], bus.divclock};
      tick    = div_q[1] & ~div_q[2];
      gate    = 1'b0;
      state_d = state_q;
      case (state_q)
         ST_HALT: state_d = (mode_press & ~bus.halt_req) ? ST_RUN : step_press ? ST_STEP : ST_HALT;
         ST_RUN: begin
            gate    = ~bus.halt_req & ~mode_press;
            state_d = (bus.halt_req | mode_press) ? ST_HALT : ST_RUN;
         end
         ST_STEP: begin
            gate    = ~mode_press;
            state_d = (mode_press | tick) ? ST_HALT : ST_STEP;
         end
         default: state_d = ST_HALT;
      endcase
      cpu_en_d     = tick & gate;
      tick_count_d = tick_count_q + CNT_W'(cpu_en_q);
   end
   // all state clears to HALT and idle outputs on reset
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         div_q        <= '0;
         state_q      <= ST_HALT;
         cpu_en_q     <= 1'b0;
         tick_count_q <= '0;
      end else begin
         div_q        <= div_d;
         state_q      <= state_d;
         cpu_en_q     <= cpu_en_d;
         tick_count_q <= tick_count_d;
      end
   end
   assign bus.cpu_en     = cpu_en_q;
   assign bus.mode       = state_q;
   assign bus.tick_count = tick_count_q;
endmodule

// File: tb/tb_proc_clk_ctrl.sv
// tb_proc_clk_ctrl: directed checks of tick latency, run/halt/step control, debounce and wrap
module tb_proc_clk_ctrl;
   logic clk;
   logic reset_n;
   int   n_cmp, n_bad;
   proc_clk_ctrl_if #(.CNT_W(8)) bus ();
   proc_clk_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
      .CLOCK_50 (clk),
      .reset_n  (reset_n),
      .bus      (bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic count_en(input int cycles, output int n, output int lat);
      n = 0;
      lat = 0;
      for (int i = 1; i <= cycles; i++) begin
         @(negedge clk);
         if (bus.cpu_en) begin
            n++;
            if (lat == 0) lat = i;
         end
      end
   endtask
   task automatic div_rise(output int n, output int lat);
      int n2, l2;
      bus.divclock = 1'b1;
      count_en(8, n, lat);
      bus.divclock = 1'b0;
      count_en(4, n2, l2);
      n += n2;
   endtask
   task automatic press(input bit m, input bit s, input int cycles);
      bus.key_mode = ~m;
      bus.key_step = ~s;
      repeat (cycles) @(negedge clk);
      bus.key_mode = 1'b1;
      bus.key_step = 1'b1;
   endtask
   initial begin
      int n, lat, tot;
      n_cmp = 0;
      n_bad = 0;
      reset_n = 1'b0;
      bus.divclock = 1'b0;
      bus.key_mode = 1'b1;
      bus.key_step = 1'b1;
      bus.halt_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cpu_en", 32'(bus.cpu_en), 0);
      chk("rst_mode", 32'(bus.mode), 0);
      chk("rst_tick", 32'(bus.tick_count), 0);
      reset_n = 1'b1;
      tot = 0;
      repeat (6) begin
         bus.divclock = ~bus.divclock;
         count_en(10, n, lat);
         tot += n;
      end
      chk("halt_no_en", 32'(tot), 0);
      chk("halt_mode", 32'(bus.mode), 0);
      chk("halt_tick", 32'(bus.tick_count), 0);
      bus.divclock = 1'b0;
      repeat (4) @(negedge clk);
      bus.key_mode = 1'b0;
      repeat (5) @(negedge clk);
      chk("mode_before_press", 32'(bus.mode), 0);
      @(negedge clk);
      chk("mode_run", 32'(bus.mode), 1);
      bus.key_mode = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         div_rise(n, lat);
         chk("run_pulse_cnt", 32'(n), 1);
         chk("run_latency", 32'(lat), 3);
      end
      chk("run_tick5", 32'(bus.tick_count), 5);
      bus.divclock = 1'b1;
      repeat (2) @(negedge clk);
      bus.halt_req = 1'b1;
      count_en(6, n, lat);
      chk("halt_req_suppress", 32'(n), 0);
      chk("halt_req_mode", 32'(bus.mode), 0);
      bus.divclock = 1'b0;
      repeat (4) @(negedge clk);
      press(1, 0, 6);
      repeat (4) @(negedge clk);
      chk("mode_ignored_halt_req", 32'(bus.mode), 0);
      press(0, 1, 6);
      repeat (2) @(negedge clk);
      chk("step_mode", 32'(bus.mode), 2);
      count_en(4, n, lat);
      chk("step_wait_no_en", 32'(n), 0);
      div_rise(n, lat);
      chk("step_pulse_cnt", 32'(n), 1);
      chk("step_latency", 32'(lat), 3);
      chk("step_back_halt", 32'(bus.mode), 0);
      chk("step_tick6", 32'(bus.tick_count), 6);
      bus.halt_req = 1'b0;
      bus.key_step = 1'b0;
      repeat (2) @(negedge clk);
      bus.key_step = 1'b1;
      @(negedge clk);
      bus.key_step = 1'b0;
      repeat (2) @(negedge clk);
      bus.key_step = 1'b1;
      repeat (6) @(negedge clk);
      chk("bounce_no_press", 32'(bus.mode), 0);
      press(0, 1, 20);
      repeat (2) @(negedge clk);
      chk("held_step_mode", 32'(bus.mode), 2);
      div_rise(n, lat);
      chk("held_step_pulse", 32'(n), 1);
      chk("held_step_halt", 32'(bus.mode), 0);
      chk("held_step_tick7", 32'(bus.tick_count), 7);
      press(1, 1, 6);
      repeat (2) @(negedge clk);
      chk("both_keys_run", 32'(bus.mode), 1);
      for (int i = 0; i < 248; i++) begin
         bus.divclock = 1'b1;
         repeat (2) @(negedge clk);
         bus.divclock = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk("preload_ff", 32'(bus.tick_count), 32'hff);
      div_rise(n, lat);
      chk("wrap_pulse", 32'(n), 1);
      chk("wrap_zero", 32'(bus.tick_count), 0);
      bus.divclock = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_reset_en", 32'(bus.cpu_en), 1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_rst_en", 32'(bus.cpu_en), 0);
      chk("async_rst_mode", 32'(bus.mode), 0);
      repeat (2) @(negedge clk);
      bus.divclock = 1'b0;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_tick", 32'(bus.tick_count), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
